// File: rtl/fifo_sched_pkg.sv
// -----------------------------------------------------------------------------
// fifo_sched_pkg
// Shared definitions for the FIFO read scheduler:
//   - sched_state_e : 2-bit scheduler state (IDLE, POP, PRESENT, GAP)
//   - DEF_*         : default parameter values for the scheduler and its interface
// -----------------------------------------------------------------------------
package fifo_sched_pkg;

  localparam int DEF_WIDTH = 8;   // data word width
  localparam int DEF_DEPTH = 16;  // FIFO depth (power of two)
  localparam int DEF_GAP_W = 4;   // width of the pacing-gap configuration

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    POP     = 2'd1,
    PRESENT = 2'd2,
    GAP     = 2'd3
  } sched_state_e;

endpackage : fifo_sched_pkg

// File: rtl/fifo_rd_scheduler_if.sv
// -----------------------------------------------------------------------------
// fifo_rd_scheduler_if
// Bundles the scheduler's FIFO read port, consumer port and control/status.
//   EN, GAP_CFG, BURST_CFG       : scheduler control
//   REMPTY, RDATA, R_INC         : FIFO read side (R_INC is the pop strobe)
//   OUT_DATA, OUT_VALID, OUT_READY : consumer valid/ready handshake
//   BUSY, BURST_DONE             : status
// Modports:
//   master : the scheduler (drives R_INC, OUT_*, BUSY, BURST_DONE)
//   slave  : FIFO/consumer/controller environment
// -----------------------------------------------------------------------------
interface fifo_rd_scheduler_if
  import fifo_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int GAP_W = DEF_GAP_W
);

  localparam int PW = $clog2(DEPTH) + 1;

  logic             EN;
  logic [GAP_W-1:0] GAP_CFG;
  logic [PW-1:0]    BURST_CFG;
  logic             REMPTY;
  logic [WIDTH-1:0] RDATA;
  logic             R_INC;
  logic [WIDTH-1:0] OUT_DATA;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic             BUSY;
  logic             BURST_DONE;

  modport master (
    input  EN, GAP_CFG, BURST_CFG, REMPTY, RDATA, OUT_READY,
    output R_INC, OUT_DATA, OUT_VALID, BUSY, BURST_DONE
  );

  modport slave (
    output EN, GAP_CFG, BURST_CFG, REMPTY, RDATA, OUT_READY,
    input  R_INC, OUT_DATA, OUT_VALID, BUSY, BURST_DONE
  );

endinterface : fifo_rd_scheduler_if

// File: rtl/rd_pace_counter.sv
// -----------------------------------------------------------------------------
// rd_pace_counter
// Down-counter that times the idle gap between presented words.
//   clk        : clock
//   rst        : synchronous, active-high reset (clears the count)
//   load_i     : load load_val_i (has priority over dec_i)
//   load_val_i : value to load
//   dec_i      : decrement by one; holds at zero
//   zero_o     : count is zero
// -----------------------------------------------------------------------------
module rd_pace_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule : rd_pace_counter

// File: rtl/fifo_rd_scheduler.sv
// -----------------------------------------------------------------------------
// fifo_rd_scheduler
// Pops words from a FIFO one at a time, presents each on a registered
// valid/ready output, and paces the stream with an optional idle gap after
// each accepted word and an optional burst length limit.
//   R_CLK : read-domain clock
//   R_RST : synchronous, active-high reset
//   bus   : fifo_rd_scheduler_if.master (control, FIFO read port, consumer port)
// Flow: IDLE -> POP (R_INC, capture RDATA) -> PRESENT (hold until OUT_READY)
//       -> GAP / POP / IDLE.
// -----------------------------------------------------------------------------
module fifo_rd_scheduler
  import fifo_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int GAP_W = DEF_GAP_W
) (
  input  logic                 R_CLK,
  input  logic                 R_RST,
  fifo_rd_scheduler_if.master  bus
);

  localparam int PW = $clog2(DEPTH) + 1;

  sched_state_e     state_q, state_d;
  logic [PW-1:0]    burst_cnt_q, burst_cnt_d;
  logic [PW-1:0]    burst_cfg_q, burst_cfg_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic             can_pop;
  logic             limit_hit;
  logic             burst_done;
  logic             gap_load;
  logic             gap_dec;
  logic             gap_zero;
  logic [GAP_W-1:0] gap_load_val;

  // Only evaluated at decision points; EN never interrupts POP or PRESENT.
  assign can_pop   = bus.EN && !bus.REMPTY;
  assign limit_hit = (burst_cfg_q != '0) && (burst_cnt_q == burst_cfg_q);

  // The counter runs GAP_CFG-1 .. 0 so GAP lasts exactly GAP_CFG cycles,
  // with expiry flagged by the zero flag in the last gap cycle.
  assign gap_load_val = bus.GAP_CFG - GAP_W'(1);

  rd_pace_counter #(
    .W (GAP_W)
  ) u_pace (
    .clk        (R_CLK),
    .rst        (R_RST),
    .load_i     (gap_load),
    .load_val_i (gap_load_val),
    .dec_i      (gap_dec),
    .zero_o     (gap_zero)
  );

  // NOTE: every signal assigned in always_comb gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    burst_cfg_d = burst_cfg_q;
    out_data_d  = out_data_q;
    gap_load    = 1'b0;
    gap_dec     = 1'b0;
    burst_done  = 1'b0;

    case (state_q)
      IDLE: begin
        if (can_pop) begin
          state_d     = POP;
          burst_cfg_d = bus.BURST_CFG;  // burst length fixed for the whole burst
        end
      end

      POP: begin
        out_data_d = bus.RDATA;
        if (burst_cnt_q != '1) begin
          burst_cnt_d = burst_cnt_q + PW'(1);
        end
        state_d = PRESENT;
      end

      PRESENT: begin
        if (bus.OUT_READY) begin
          if (limit_hit) begin
            burst_done  = 1'b1;
            burst_cnt_d = '0;
          end
          if (bus.GAP_CFG != '0) begin
            state_d  = GAP;
            gap_load = 1'b1;
          end else if (!limit_hit && can_pop) begin
            state_d = POP;
          end else begin
            state_d = IDLE;
          end
        end
      end

      GAP: begin
        if (gap_zero) begin
          state_d = can_pop ? POP : IDLE;
        end else begin
          gap_dec = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) begin
      burst_cnt_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge R_CLK) begin
    if (R_RST) begin
      // NOTE: the output data register is reset too, so a word pending at
      // reset is discarded and OUT_DATA reads 0 afterwards.
      state_q     <= IDLE;
      burst_cnt_q <= '0;
      burst_cfg_q <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      burst_cfg_q <= burst_cfg_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.R_INC      = (state_q == POP);
  assign bus.OUT_VALID  = (state_q == PRESENT);
  assign bus.OUT_DATA   = out_data_q;
  assign bus.BUSY       = (state_q != IDLE);
  assign bus.BURST_DONE = burst_done;

endmodule : fifo_rd_scheduler

// File: tb/tb_fifo_rd_scheduler.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_scheduler
// Self-checking bench: the bench itself plays the FIFO (a queue), the consumer
// and the controller. A transaction-level model predicts every output in
// every cycle; directed scenarios add literal expectations, followed by a
// long randomized run.
// -----------------------------------------------------------------------------
module tb_fifo_rd_scheduler;
  import fifo_sched_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int GAP_W = 4;
  localparam int PW    = $clog2(DEPTH) + 1;
  localparam int SAT   = (1 << PW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_rd_scheduler_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .GAP_W(GAP_W)) bus ();

  fifo_rd_scheduler #(.WIDTH(WIDTH), .DEPTH(DEPTH), .GAP_W(GAP_W)) dut (
    .R_CLK (clk),
    .R_RST (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stimulus for the next cycle
  bit s_en, s_ready, s_rst;
  int s_gap, s_burst;
  logic [WIDTH-1:0] fifo_q[$];

  // Transaction-level model of the scheduler
  typedef enum {M_IDLE, M_READ, M_SHOW, M_PAUSE} mode_e;
  mode_e          m_mode  = M_IDLE;
  bit             m_known = 1'b0;
  logic [WIDTH-1:0] m_data = '0;
  int             m_gap_left = 0;
  int             m_words = 0;   // words popped in the current burst
  int             m_limit = 0;   // burst length fixed at burst start

  int n_accept = 0;

  task automatic advance();
    bit avail;
    bit go;
    bit lim;
    avail = (fifo_q.size() != 0);
    go    = s_en && avail;
    if (s_rst) begin
      m_mode = M_IDLE; m_data = '0; m_gap_left = 0; m_words = 0; m_limit = 0;
      m_known = 1'b1;
      return;
    end
    case (m_mode)
      M_IDLE: if (go) begin
        m_mode = M_READ; m_limit = s_burst; m_words = 0;
      end
      M_READ: begin
        m_data  = avail ? fifo_q.pop_front() : '0;
        m_words = (m_words < SAT) ? m_words + 1 : SAT;
        m_mode  = M_SHOW;
      end
      M_SHOW: if (s_ready) begin
        lim = (m_limit != 0) && (m_words == m_limit);
        if (lim) m_words = 0;
        if (s_gap != 0) begin
          m_mode = M_PAUSE; m_gap_left = s_gap;
        end else if (!lim && go) begin
          m_mode = M_READ;
        end else begin
          m_mode = M_IDLE;
        end
      end
      M_PAUSE: begin
        if (m_gap_left <= 1) m_mode = go ? M_READ : M_IDLE;
        else m_gap_left--;
      end
      default: m_mode = M_IDLE;
    endcase
    if (m_mode == M_IDLE) m_words = 0;
  endtask

  // One clock cycle: drive inputs after the falling edge, compare the
  // settled outputs against the model, then step the model to the next cycle.
  task automatic step();
    bit e_done;
    @(negedge clk);
    rst           = s_rst;
    bus.EN        = s_en;
    bus.OUT_READY = s_ready;
    bus.GAP_CFG   = GAP_W'(s_gap);
    bus.BURST_CFG = PW'(s_burst);
    bus.REMPTY    = (fifo_q.size() == 0);
    bus.RDATA     = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    #1;
    e_done = (m_mode == M_SHOW) && s_ready && (m_limit != 0) && (m_words == m_limit);
    if (m_known) begin
      check("R_INC",      32'(bus.R_INC),      32'(m_mode == M_READ));
      check("OUT_VALID",  32'(bus.OUT_VALID),  32'(m_mode == M_SHOW));
      check("OUT_DATA",   32'(bus.OUT_DATA),   32'(m_data));
      check("BUSY",       32'(bus.BUSY),       32'(m_mode != M_IDLE));
      check("BURST_DONE", 32'(bus.BURST_DONE), 32'(e_done));
    end
    if (bus.OUT_VALID && s_ready) n_accept++;
    advance();
  endtask

  task automatic wait_show(input string name);
    int g;
    g = 0;
    while (m_mode != M_SHOW && g < 40) begin
      step();
      g++;
    end
    check(name, 32'(g < 40), 32'd1);
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    s_en = 1'b0; s_ready = 1'b1;
    while (m_mode != M_IDLE && g < 60) begin
      step();
      g++;
    end
    check(name, 32'(g < 60), 32'd1);
    fifo_q.delete();
  endtask

  bit vlog[24], rlog[24], blog[24], dlog[24];

  task automatic log_run(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      vlog[i] = bus.OUT_VALID;
      rlog[i] = bus.R_INC;
      blog[i] = bus.BUSY;
      dlog[i] = bus.BURST_DONE;
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int a, b, n0, d, hs, nd, ngap;

    s_rst = 1'b1; s_en = 1'b0; s_ready = 1'b0; s_gap = 0; s_burst = 0;
    step();
    step();

    // Latency and throughput with no gap and no burst limit
    s_rst = 1'b0; s_en = 1'b1; s_ready = 1'b1;
    repeat (6) fifo_q.push_back(8'hA5);
    step();
    check("rst_r_inc",     32'(bus.R_INC),      32'd0);
    check("rst_out_valid", 32'(bus.OUT_VALID),  32'd0);
    check("rst_out_data",  32'(bus.OUT_DATA),   32'd0);
    check("rst_busy",      32'(bus.BUSY),       32'd0);
    check("rst_done",      32'(bus.BURST_DONE), 32'd0);
    step();
    check("lat_r_inc_c1",  32'(bus.R_INC),      32'd1);
    check("lat_valid_c1",  32'(bus.OUT_VALID),  32'd0);
    step();
    check("lat_valid_c2",  32'(bus.OUT_VALID),  32'd1);
    check("lat_data_c2",   32'(bus.OUT_DATA),   32'hA5);
    n0 = n_accept;
    repeat (8) step();
    check("thru_8cyc", 32'(n_accept - n0), 32'd4);
    drain("drain_thru");

    // Backpressure holds the presented word
    s_en = 1'b1; s_ready = 1'b0;
    fifo_q.push_back(8'h3C);
    wait_show("wait_hold");
    n0 = n_accept;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_valid", 32'(bus.OUT_VALID), 32'd1);
      check("hold_data",  32'(bus.OUT_DATA),  32'h3C);
      check("hold_r_inc", 32'(bus.R_INC),     32'd0);
    end
    s_ready = 1'b1;
    step();
    s_en = 1'b0;
    repeat (3) step();
    check("hold_accepts", 32'(n_accept - n0), 32'd1);
    drain("drain_hold");

    // Gap of 3 between two words, then IDLE once the FIFO is empty
    s_en = 1'b1; s_ready = 1'b1; s_gap = 3; s_burst = 0;
    fifo_q.push_back(8'h11);
    fifo_q.push_back(8'h22);
    log_run(16);
    a = -1; b = -1;
    for (int i = 0; i < 16; i++) begin
      if (vlog[i] && a < 0) a = i;
      else if (vlog[i] && a >= 0 && b < 0) b = i;
    end
    if (a < 0) a = 0;
    if (b < 0) b = 0;
    ngap = 0;
    for (int i = a + 1; i < b; i++) if (blog[i] && !rlog[i]) ngap++;
    check("gap_first_valid", 32'(a), 32'd2);
    check("gap_idle_cycles", 32'(ngap), 32'd3);
    check("gap_spacing",     32'(b - a), 32'd5);
    check("gap_busy_tail",   32'(blog[(b + 3) % 16]), 32'd1);
    check("gap_then_idle",   32'(blog[(b + 4) % 16]), 32'd0);
    drain("drain_gap");

    // Burst of 4 out of 6 words
    s_en = 1'b1; s_ready = 1'b1; s_gap = 0; s_burst = 4;
    for (int i = 1; i <= 6; i++) fifo_q.push_back(8'(i));
    log_run(20);
    hs = 0; nd = 0; d = 0;
    for (int i = 0; i < 20; i++) begin
      if (vlog[i]) hs++;
      if (dlog[i]) begin
        nd++;
        d = i;
        check("burst_done_on_4th", 32'(hs), 32'd4);
      end
    end
    check("burst_done_count", 32'(nd), 32'd1);
    check("burst_done_cycle", 32'(d), 32'd8);
    check("burst_idle_after", 32'(blog[d + 1]), 32'd0);
    check("burst_restart",    32'(rlog[d + 2]), 32'd1);
    check("burst_words",      32'(hs), 32'd6);
    drain("drain_burst");

    // Reset while a word is presented and not accepted
    s_en = 1'b1; s_ready = 1'b0; s_gap = 0; s_burst = 0;
    fifo_q.push_back(8'h77);
    wait_show("wait_rst");
    s_rst = 1'b1;
    step();
    s_rst = 1'b0; s_en = 1'b0;
    step();
    check("rstp_valid", 32'(bus.OUT_VALID), 32'd0);
    check("rstp_busy",  32'(bus.BUSY),      32'd0);
    check("rstp_r_inc", 32'(bus.R_INC),     32'd0);
    check("rstp_data",  32'(bus.OUT_DATA),  32'd0);
    drain("drain_rst");

    // EN dropped while presenting: word completes, no further pops
    s_en = 1'b1; s_ready = 1'b0;
    fifo_q.push_back(8'h41);
    fifo_q.push_back(8'h42);
    fifo_q.push_back(8'h43);
    wait_show("wait_en");
    s_en = 1'b0;
    step();
    check("en_off_held", 32'(bus.OUT_VALID), 32'd1);
    check("en_off_data", 32'(bus.OUT_DATA),  32'h41);
    n0 = n_accept;
    s_ready = 1'b1;
    step();
    check("en_off_accept", 32'(n_accept - n0), 32'd1);
    for (int i = 0; i < 6; i++) begin
      step();
      check("en_off_no_pop", 32'(bus.R_INC), 32'd0);
      check("en_off_idle",   32'(bus.BUSY),  32'd0);
    end
    drain("drain_en");

    // Randomized traffic, configuration churn and occasional resets
    for (int i = 0; i < 4000; i++) begin
      s_rst   = ($urandom_range(0, 299) == 0);
      s_en    = ($urandom_range(0, 3) != 0);
      s_ready = ($urandom_range(0, 2) != 0);
      s_gap   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      s_burst = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 5)) : 0;
      if (fifo_q.size() < DEPTH && $urandom_range(0, 1) == 0) begin
        fifo_q.push_back(WIDTH'($urandom));
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_fifo_rd_scheduler
